// File: rtl/pixel_scan_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_scan_tx_pkg
//  Description : Shared OLED display constants and the frame-scan FSM state
//                encoding used by pixel_scan_tx and its serializer.
//  Revision    : 1.0  initial release
// ============================================================================
package pixel_scan_tx_pkg;

    // Panel geometry (96x64 colour OLED)
    localparam int OLED_WIDTH  = 96;
    localparam int OLED_HEIGHT = 64;
    localparam int PIX_COUNT   = OLED_WIDTH * OLED_HEIGHT;

    // RGB565 pixel width and the pixel address width driven to the compositor
    localparam int PIX_W     = 16;
    localparam int INDEX_W   = 13;
    localparam int BIT_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_scan_tx_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pixel_shifter
//  Description : Serializes one RGB565 pixel MSB first. Each bit lasts
//                2*CLK_DIV clocks: sclk low for the first half, high for the
//                second. mosi only changes while sclk is low.
//  Ports       : clock, reset_n   - clock / async active-low reset
//                load, data       - capture a pixel and start shifting
//                busy             - a pixel is in flight
//                done             - last clock of the pixel (combinational)
//                sclk, mosi       - serial clock (idle low) and data
//  Revision    : 1.0  initial release
// ============================================================================
module spi_pixel_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                load,
    input  logic [pixel_scan_tx_pkg::PIX_W-1:0] data,
    output logic                                busy,
    output logic                                done,
    output logic                                sclk,
    output logic                                mosi
);
    import pixel_scan_tx_pkg::*;

    localparam int c_div_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

    logic [c_div_w-1:0]   r_div;
    logic [BIT_CNT_W-1:0] r_bit;
    logic [PIX_W-1:0]     r_shreg;
    logic                 r_busy;
    logic                 r_sclk;
    logic                 w_half_end;

    assign w_half_end = (r_div == c_div_last);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_busy  <= 1'b0;
            r_sclk  <= 1'b0;
        end else if (load) begin
            r_div   <= '0;
            r_bit   <= '0;
            r_shreg <= data;
            r_busy  <= 1'b1;
            r_sclk  <= 1'b0;
        end else if (r_busy && w_half_end) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            // End of a high half closes the bit: advance or finish
            if (r_sclk) begin
                if (r_bit == BIT_CNT_W'(PIX_W - 1)) begin
                    r_busy <= 1'b0;
                end else begin
                    r_bit   <= r_bit + BIT_CNT_W'(1);
                    r_shreg <= {r_shreg[PIX_W-2:0], 1'b0};
                end
            end
        end else if (r_busy) begin
            r_div <= r_div + c_div_w'(1);
        end
    end

    // Lets the scan FSM leave SHIFT on the same edge sclk drops after bit 0
    assign done = r_busy && r_sclk && w_half_end && (r_bit == BIT_CNT_W'(PIX_W - 1));
    assign busy = r_busy;
    assign sclk = r_sclk;
    assign mosi = r_shreg[PIX_W-1];

endmodule
`default_nettype wire

// File: rtl/pixel_scan_tx.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_scan_tx
//  Description : Walks the frame buffer index 0..PIX_COUNT-1, waits PIPE_LAT
//                clocks for the compositor pixel, then streams it over SPI.
//  Ports       : clock, reset_n  - clock / async active-low reset
//                frame_start     - one-cycle frame request (ignored if busy)
//                data            - RGB565 pixel for index, PIPE_LAT later
//                index           - pixel address to the compositor
//                busy            - frame in progress
//                frame_done      - one-cycle pulse when the frame completes
//                sclk, mosi, cs_n- SPI to the panel
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_scan_tx #(
    parameter int PIX_COUNT = pixel_scan_tx_pkg::PIX_COUNT,
    parameter int PIPE_LAT  = 2,   // minimum 1
    parameter int CLK_DIV   = 2    // minimum 1
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic                                  frame_start,
    input  logic [pixel_scan_tx_pkg::PIX_W-1:0]   data,
    output logic [pixel_scan_tx_pkg::INDEX_W-1:0] index,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic                                  sclk,
    output logic                                  mosi,
    output logic                                  cs_n
);
    import pixel_scan_tx_pkg::*;

    localparam int c_lat_w = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [c_lat_w-1:0] c_lat_last   = c_lat_w'(PIPE_LAT - 1);
    localparam logic [INDEX_W-1:0] c_index_last = INDEX_W'(PIX_COUNT - 1);

    scan_state_t        r_state, w_state_nxt;
    logic [INDEX_W-1:0] r_index, w_index_nxt;
    logic [c_lat_w-1:0] r_lat_cnt, w_lat_cnt_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_cs_n, w_cs_n_nxt;
    logic               r_frame_done, w_frame_done_nxt;
    logic               w_load;
    logic               w_shift_busy;
    logic               w_shift_done;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_index      <= '0;
            r_lat_cnt    <= '0;
            r_busy       <= 1'b0;
            r_cs_n       <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_index      <= w_index_nxt;
            r_lat_cnt    <= w_lat_cnt_nxt;
            r_busy       <= w_busy_nxt;
            r_cs_n       <= w_cs_n_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_index_nxt      = r_index;
        w_lat_cnt_nxt    = r_lat_cnt;
        w_busy_nxt       = r_busy;
        w_cs_n_nxt       = r_cs_n;
        w_frame_done_nxt = 1'b0;
        w_load           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (frame_start) begin
                    w_index_nxt   = '0;
                    w_lat_cnt_nxt = '0;
                    w_busy_nxt    = 1'b1;
                    w_cs_n_nxt    = 1'b0;
                    w_state_nxt   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Compositor data is valid once PIPE_LAT clocks have elapsed
                if ((r_lat_cnt == c_lat_last) && !w_shift_busy) begin
                    w_load        = 1'b1;
                    w_lat_cnt_nxt = '0;
                    w_state_nxt   = ST_SHIFT;
                end else if (r_lat_cnt != c_lat_last) begin
                    w_lat_cnt_nxt = r_lat_cnt + c_lat_w'(1);
                end
            end
            ST_SHIFT: begin
                if (w_shift_done) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (r_index == c_index_last) begin
                    // Frame end flags are registered on entry so they are
                    // visible for exactly the DONE cycle
                    w_index_nxt      = '0;
                    w_busy_nxt       = 1'b0;
                    w_cs_n_nxt       = 1'b1;
                    w_frame_done_nxt = 1'b1;
                    w_state_nxt      = ST_DONE;
                end else begin
                    w_index_nxt = r_index + INDEX_W'(1);
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DONE: begin
                // A frame_start seen here is dropped, not queued
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    spi_pixel_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (w_load),
        .data    (data),
        .busy    (w_shift_busy),
        .done    (w_shift_done),
        .sclk    (sclk),
        .mosi    (mosi)
    );

    assign index      = r_index;
    assign busy       = r_busy;
    assign cs_n       = r_cs_n;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_pixel_scan_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_scan_tx
//  Description : Self-checking bench for pixel_scan_tx. Two instances: a
//                4-pixel frame at CLK_DIV=1 and a 2-pixel frame at CLK_DIV=3.
//                A frame-time model predicts every output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pixel_scan_tx;

    localparam int LAT  = 2;
    localparam int CD1  = 1;
    localparam int PIX1 = 4;
    localparam int CD3  = 3;
    localparam int PIX3 = 2;
    localparam int P1   = LAT + 32*CD1 + 1;
    localparam int P3   = LAT + 32*CD3 + 1;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fs1, fs3;
    logic        idx_mode;
    logic [15:0] din1_reg, din3;
    logic [12:0] index1, index3;
    logic        busy1, fd1, sclk1, mosi1, csn1;
    logic        busy3, fd3, sclk3, mosi3, csn3;
    wire  [15:0] din1 = idx_mode ? {3'b000, index1} : din1_reg;

    always #5 clock = ~clock;

    pixel_scan_tx #(.PIX_COUNT(PIX1), .PIPE_LAT(LAT), .CLK_DIV(CD1)) dut1 (
        .clock(clock), .reset_n(reset_n), .frame_start(fs1), .data(din1),
        .index(index1), .busy(busy1), .frame_done(fd1), .sclk(sclk1),
        .mosi(mosi1), .cs_n(csn1));

    pixel_scan_tx #(.PIX_COUNT(PIX3), .PIPE_LAT(LAT), .CLK_DIV(CD3)) dut3 (
        .clock(clock), .reset_n(reset_n), .frame_start(fs3), .data(din3),
        .index(index3), .busy(busy3), .frame_done(fd3), .sclk(sclk3),
        .mosi(mosi3), .cs_n(csn3));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- frame-time model ----------------
    typedef struct packed {
        logic [12:0] index;
        logic        busy;
        logic        fd;
        logic        sclk;
        logic        csn;
        logic        mosi_v;
        logic        mosi;
    } exp_t;

    // Outputs at frame time t (cycles after the accepting edge)
    function automatic exp_t model(input bit act, input int t, input int cd,
                                   input int pix, input logic [15:0] w);
        exp_t e;
        int per, p, o, s;
        per   = LAT + 32*cd + 1;
        e     = '0;
        e.csn = 1'b1;
        if (act) begin
            if (t < pix*per) begin
                p       = t / per;
                o       = t % per;
                e.index = 13'(p);
                e.busy  = 1'b1;
                e.csn   = 1'b0;
                if (o >= LAT && o < LAT + 32*cd) begin
                    s        = o - LAT;
                    e.sclk   = ((s % (2*cd)) >= cd);
                    e.mosi_v = 1'b1;
                    e.mosi   = w[15 - s/(2*cd)];
                end
            end else if (t == pix*per) begin
                e.fd = 1'b1;
            end
        end
        return e;
    endfunction

    bit          a1 = 0, a3 = 0;
    int          t1 = 0, t3 = 0;
    logic [15:0] w1 = '0, w3 = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a1 = 0;
            a3 = 0;
        end else begin
            if (a1) begin
                if (t1 < PIX1*P1 && (t1 % P1) == LAT-1) w1 = din1;
                t1++;
                if (t1 > PIX1*P1) a1 = 0;
            end else if (fs1) begin
                a1 = 1;
                t1 = 0;
            end
            if (a3) begin
                if (t3 < PIX3*P3 && (t3 % P3) == LAT-1) w3 = din3;
                t3++;
                if (t3 > PIX3*P3) a3 = 0;
            end else if (fs3) begin
                a3 = 1;
                t3 = 0;
            end
        end
    end

    int   nfd1 = 0, nwin1 = 0;
    logic prev_csn1 = 1'b1;

    always @(negedge clock) begin
        exp_t e;
        e = model(a1, t1, CD1, PIX1, w1);
        chk("dut1 index", index1, e.index);
        chk("dut1 busy", busy1, e.busy);
        chk("dut1 frame_done", fd1, e.fd);
        chk("dut1 sclk", sclk1, e.sclk);
        chk("dut1 cs_n", csn1, e.csn);
        if (e.mosi_v) chk("dut1 mosi", mosi1, e.mosi);
        e = model(a3, t3, CD3, PIX3, w3);
        chk("dut3 index", index3, e.index);
        chk("dut3 busy", busy3, e.busy);
        chk("dut3 frame_done", fd3, e.fd);
        chk("dut3 sclk", sclk3, e.sclk);
        chk("dut3 cs_n", csn3, e.csn);
        if (e.mosi_v) chk("dut3 mosi", mosi3, e.mosi);
        if (fd1 === 1'b1) nfd1++;
        if (prev_csn1 === 1'b1 && csn1 === 1'b0) nwin1++;
        prev_csn1 = csn1;
    end

    // Word collector: mosi sampled on sclk rising edges of dut1
    logic [15:0] cur = '0;
    int          nb  = 0;
    logic [15:0] words[$];

    always @(posedge sclk1 or negedge reset_n) begin
        if (!reset_n) begin
            nb = 0;
        end else begin
            cur = {cur[14:0], mosi1};
            nb++;
            if (nb == 16) begin
                words.push_back(cur);
                nb = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic start1(output int s);
        @(negedge clock);
        fs1 = 1'b1;
        s   = cyc;
        @(negedge clock);
        fs1 = 1'b0;
    endtask

    task automatic start3(output int s);
        @(negedge clock);
        fs3 = 1'b1;
        s   = cyc;
        @(negedge clock);
        fs3 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int s, input int bound, output int lat);
        int n;
        n   = 0;
        lat = -1;
        while (n < bound) begin
            if (((which == 1) ? fd1 : fd3) === 1'b1) begin
                lat = cyc - s;
                break;
            end
            @(negedge clock);
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        int s, lat, b_fd, b_win, hi, lo, n;
        reset_n  = 1'b0;
        fs1      = 1'b0;
        fs3      = 1'b0;
        idx_mode = 1'b0;
        din1_reg = 16'h0000;
        din3     = 16'h5A3C;
        repeat (3) @(negedge clock);
        chk("reset index", index1, 0);
        chk("reset busy", busy1, 0);
        chk("reset cs_n", csn1, 1);
        chk("reset sclk", sclk1, 0);
        chk("reset mosi", mosi1, 0);
        chk("reset frame_done", fd1, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Basic pixel: constant A5C3, latency 4*35+1
        din1_reg = 16'hA5C3;
        words.delete();
        start1(s);
        wait_done(1, s, 400, lat);
        chk("basic latency", lat, 141);
        repeat (3) @(negedge clock);
        chk("basic word count", words.size(), 4);
        for (int i = 0; i < 4; i++) chk("basic word", words[i], 16'hA5C3);

        // Index order: data follows index
        idx_mode = 1'b1;
        words.delete();
        start1(s);
        wait_done(1, s, 400, lat);
        repeat (3) @(negedge clock);
        chk("order word count", words.size(), 4);
        for (int i = 0; i < 4; i++) chk("order word", words[i], i);

        // Start while busy, and again in the DONE cycle
        b_fd  = nfd1;
        b_win = nwin1;
        start1(s);
        repeat (10) @(negedge clock);
        fs1 = 1'b1;
        @(negedge clock);
        fs1 = 1'b0;
        wait_done(1, s, 400, lat);
        chk("busy latency", lat, 141);
        fs1 = 1'b1;
        @(negedge clock);
        fs1 = 1'b0;
        repeat (20) @(negedge clock);
        chk("busy frame_done count", nfd1 - b_fd, 1);
        chk("busy cs_n windows", nwin1 - b_win, 1);
        chk("busy after done", busy1, 0);
        chk("cs_n after done", csn1, 1);

        // Reset during the 3rd bit (high half) of pixel 1
        start1(s);
        repeat (42) @(negedge clock);
        chk("pre-reset sclk", sclk1, 1);
        chk("pre-reset index", index1, 1);
        b_fd = nfd1;
        #2 reset_n = 1'b0;
        #1;
        chk("mid reset cs_n", csn1, 1);
        chk("mid reset sclk", sclk1, 0);
        chk("mid reset busy", busy1, 0);
        chk("mid reset mosi", mosi1, 0);
        chk("mid reset index", index1, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (60) @(negedge clock);
        chk("no done after reset", nfd1 - b_fd, 0);
        words.delete();
        start1(s);
        wait_done(1, s, 400, lat);
        chk("post-reset latency", lat, 141);
        repeat (3) @(negedge clock);
        chk("post-reset word count", words.size(), 4);
        for (int i = 0; i < 4; i++) chk("post-reset word", words[i], i);

        // Data latch: FFFF -> 0000 on the 5th SHIFT cycle of pixel 0
        idx_mode = 1'b0;
        din1_reg = 16'hFFFF;
        words.delete();
        start1(s);
        repeat (6) @(negedge clock);
        din1_reg = 16'h0000;
        wait_done(1, s, 400, lat);
        repeat (3) @(negedge clock);
        chk("latch word count", words.size(), 4);
        chk("latch word 0", words[0], 16'hFFFF);
        chk("latch word 1", words[1], 16'h0000);

        // Divider: CLK_DIV=3
        start3(s);
        n = 0;
        while (sclk3 !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        hi = 0;
        while (sclk3 === 1'b1 && hi < 20) begin
            hi++;
            @(negedge clock);
        end
        lo = 0;
        while (sclk3 === 1'b0 && lo < 20) begin
            lo++;
            @(negedge clock);
        end
        chk("div3 sclk high", hi, 3);
        chk("div3 sclk low", lo, 3);
        wait_done(3, s, 600, lat);
        chk("div3 latency", lat, 2*99 + 1);
        repeat (5) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
